ddr3_playback_reader: RTL and testbench
=======================================

Name: ddr3_playback_reader

Overview:
Read-side sequencer for the DDR3 sample store. It issues 256-bit read commands to the MIG user interface, starting at a programmed base address, for a programmed word count, with optional looping. Returned words go into the DDR3-to-playback FIFO, which feeds the USB pipe-out now and the DAC later. Issue is credit-limited so the FIFO can never overflow, because MIG read returns cannot be back-pressured.

Parameters:
ADDR_W, 29, MIG app_addr width
DATA_W, 256, MIG UI data width / FIFO write width
ADDR_STEP, 8, app_addr increment per 256-bit word (x32 DDR3, BL8)
LEN_W, 24, width of word-count register
FIFO_DEPTH, 512, downstream FIFO capacity in DATA_W words
CNT_W, 10, width of fifo_wr_count and in-flight counter (holds FIFO_DEPTH)

Ports:
clk  in  1  UI clock; all logic on rising edge
sys_rst  in  1  async active-low reset
start  in  1  1-cycle pulse; begin playback (ignored unless IDLE)
abort  in  1  1-cycle pulse; stop issuing, drain, return IDLE
loop_en  in  1  restart at base_addr after last word; sampled each wrap
base_addr  in  ADDR_W  first word address; captured on start
num_words  in  LEN_W  words per pass; captured on start; 0 = no-op
init_calib_complete  in  1  MIG calibration done
app_rdy  in  1  MIG command accept
app_en  out  1  command valid
app_cmd  out  3  fixed 3'b001 (read)
app_addr  out  ADDR_W  command address
app_rd_data  in  DATA_W  MIG read data
app_rd_data_valid  in  1  read data strobe
fifo_din  out  DATA_W  FIFO write data
fifo_wr_en  out  1  FIFO write strobe
fifo_wr_count  in  CNT_W  FIFO occupancy
busy  out  1  not IDLE
done  out  1  1-cycle pulse on non-loop completion or abort completion
pass_cnt  out  16  completed passes, wraps at 0xFFFF
overflow_err  out  1  sticky; data received with fifo full condition

Behaviour:
- Reset (async assert, sync deassert internally): state IDLE; app_en=0, app_addr=0, fifo_wr_en=0, fifo_din=0, busy=0, done=0, pass_cnt=0, overflow_err=0, in-flight=0. app_cmd is a constant 3'b001.
- States: IDLE, WAIT_CAL, ISSUE, DRAIN.
- IDLE: on start with num_words≠0, capture base_addr and num_words, set remaining=num_words and cur_addr=base_addr, go to WAIT_CAL. On start with num_words=0, pulse done next cycle and stay in IDLE.
- WAIT_CAL: go to ISSUE once init_calib_complete=1.
- ISSUE: app_en=1 while credit_ok = (fifo_wr_count + inflight) < FIFO_DEPTH.
  - On app_en&app_rdy: cur_addr += ADDR_STEP (wraps mod 2^ADDR_W), remaining -= 1, inflight += 1.
  - app_addr and app_en are held stable while app_rdy=0 (MIG UI rule). app_en may drop only after an accept or when credit_ok falls.
- Last word accepted:
  - If loop_en=1: reload cur_addr=base_addr and remaining=num_words (captured values), pass_cnt += 1, stay in ISSUE with no bubble required.
  - If loop_en=0: go to DRAIN.
- DRAIN: app_en=0. When inflight=0: pass_cnt += 1, done pulses, go to IDLE.
- Data path, every state: app_rd_data_valid → fifo_wr_en=1 and fifo_din=app_rd_data on the next cycle (1-cycle registered latency). inflight decrements on the same edge the valid is registered.
- Issue and return in the same cycle: inflight is unchanged.
- overflow_err sets if app_rd_data_valid=1 while fifo_wr_count ≥ FIFO_DEPTH. The data is still written.
- abort in WAIT_CAL or ISSUE: cancel any un-accepted command (app_en=0 next cycle), go to DRAIN, and do not increment pass_cnt. done pulses after drain completes. abort in IDLE or DRAIN has no effect. start outside IDLE is ignored.
- init_calib_complete dropping mid-ISSUE: app_en is forced to 0 and the block waits in ISSUE, keeping position.
- busy = (state ≠ IDLE).

Test Plan:
- Reset, calib=1, base=0x100, num_words=4, app_rdy=1, MIG returns data 10 cycles after each accept → app_addr 0x100,0x108,0x110,0x118; 4 fifo writes with data in order; done pulse after the 4th write; pass_cnt=1; busy falls.
- app_rdy low for 3 cycles on the second command → app_en and app_addr=0x108 stay stable for all 3 cycles; exactly 4 accepts total.
- fifo_wr_count=FIFO_DEPTH-2, returns stalled, num_words=10 → only 2 commands issued until fifo_wr_count drops; overflow_err stays 0.
- loop_en=1, num_words=3 → address sequence base,+8,+16,base,...; pass_cnt increments each wrap; clearing loop_en leads to done after the current pass.
- abort after 2 of 8 accepts with 2 in flight → app_en=0 next cycle; both outstanding words written; done pulse; pass_cnt unchanged.
- sys_rst asserted mid-ISSUE → all outputs return to reset values immediately (async); a later start runs normally.

Source files
------------

// File: rtl/ddr3_playback_reader.sv
// Read-side sequencer for the DDR3 sample store: issues credit-limited MIG read
// commands over a programmed address window and forwards returned words to the playback FIFO.
module ddr3_playback_reader #(
  parameter int ADDR_W     = 29,
  parameter int DATA_W     = 256,
  parameter int ADDR_STEP  = 8,
  parameter int LEN_W      = 24,
  parameter int FIFO_DEPTH = 512,
  parameter int CNT_W      = 10
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              abort,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_words,
  input  logic              init_calib_complete,
  input  logic              app_rdy,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_wr_en,
  input  logic [CNT_W-1:0]  fifo_wr_count,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pass_cnt,
  output logic              overflow_err
);

  localparam int SUM_W = CNT_W + 2;

  typedef enum logic [1:0] {IDLE, WAIT_CAL, ISSUE, DRAIN} state_t;

  state_t            state;
  logic [1:0]        rst_sync;
  logic              rst_n;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  num_q;
  logic [LEN_W-1:0]  remaining;
  logic [CNT_W-1:0]  inflight;
  logic              aborted;
  logic              accept;
  logic              last_accept;
  logic [SUM_W-1:0]  inflight_nxt;
  logic              credit_ok;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign app_cmd     = 3'b001;
  assign busy        = (state != IDLE);
  assign accept      = app_en & app_rdy;
  assign last_accept = accept && (remaining == LEN_W'(1));

  always_comb begin
    // NOTE: default first so no latch is inferred on any path.
    inflight_nxt = SUM_W'(inflight);
    if (accept) inflight_nxt = inflight_nxt + SUM_W'(1);
    if (app_rd_data_valid && inflight_nxt != '0) inflight_nxt = inflight_nxt - SUM_W'(1);
  end

  // Credit looks at the in-flight count after this edge, so app_en never outruns FIFO space.
  assign credit_ok = (SUM_W'(fifo_wr_count) + inflight_nxt) < SUM_W'(FIFO_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      app_en    <= 1'b0;
      app_addr  <= '0;
      base_q    <= '0;
      num_q     <= '0;
      remaining <= '0;
      inflight  <= '0;
      aborted   <= 1'b0;
      done      <= 1'b0;
      pass_cnt  <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      done     <= 1'b0;
      inflight <= inflight_nxt[CNT_W-1:0];

      if (accept) begin
        if (remaining == LEN_W'(1)) begin
          if (loop_en) begin
            app_addr  <= base_q;
            remaining <= num_q;
            pass_cnt  <= pass_cnt + 16'd1;
          end
        end else begin
          app_addr  <= app_addr + ADDR_W'(ADDR_STEP);
          remaining <= remaining - LEN_W'(1);
        end
      end

      case (state)
        IDLE: begin
          app_en <= 1'b0;
          if (start) begin
            if (num_words != '0) begin
              base_q    <= base_addr;
              num_q     <= num_words;
              app_addr  <= base_addr;
              remaining <= num_words;
              aborted   <= 1'b0;
              state     <= WAIT_CAL;
            end else begin
              done <= 1'b1;
            end
          end
        end
        WAIT_CAL: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= DRAIN;
          end else if (init_calib_complete) begin
            app_en <= credit_ok;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          // A held command keeps app_addr because only an accept moves it.
          if (abort) begin
            app_en  <= 1'b0;
            aborted <= 1'b1;
            state   <= DRAIN;
          end else if (last_accept && !loop_en) begin
            app_en <= 1'b0;
            state  <= DRAIN;
          end else begin
            app_en <= init_calib_complete && credit_ok;
          end
        end
        DRAIN: begin
          app_en <= 1'b0;
          if (inflight == '0) begin
            done  <= 1'b1;
            state <= IDLE;
            if (!aborted) pass_cnt <= pass_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return path: one register stage, never back-pressured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en   <= 1'b0;
      fifo_din     <= '0;
      overflow_err <= 1'b0;
    end else begin
      fifo_wr_en <= app_rd_data_valid;
      if (app_rd_data_valid) fifo_din <= app_rd_data;
      if (app_rd_data_valid && (SUM_W'(fifo_wr_count) >= SUM_W'(FIFO_DEPTH)))
        overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr3_playback_reader.sv
// Self-checking bench for ddr3_playback_reader: a MIG responder model, a
// transaction-level reference of the playback session, and per-cycle comparison.
module tb_ddr3_playback_reader;

  localparam int ADDR_W = 29;
  localparam int DATA_W = 256;
  localparam int LEN_W  = 24;
  localparam int CNT_W  = 10;
  localparam int DEPTH  = 512;
  localparam int STEP   = 8;

  logic              clk;
  logic              sys_rst;
  logic              start, abort, loop_en;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  num_words;
  logic              init_calib_complete, app_rdy;
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic [DATA_W-1:0] fifo_din;
  logic              fifo_wr_en;
  logic [CNT_W-1:0]  fifo_wr_count;
  logic              busy, done;
  logic [15:0]       pass_cnt;
  logic              overflow_err;

  ddr3_playback_reader dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .abort(abort), .loop_en(loop_en),
    .base_addr(base_addr), .num_words(num_words), .init_calib_complete(init_calib_complete),
    .app_rdy(app_rdy), .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_wr_count(fifo_wr_count),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {P_IDLE, P_WAIT, P_ISSUE, P_DRAIN} phase_t;
  typedef struct {logic [ADDR_W-1:0] addr; int due;} ret_t;

  int n_vec = 0, n_bad = 0;
  int cyc = 0;

  // Stimulus knobs
  int rdy_prob = 100, lat = 10, force_low = 0, abort_after = 0;
  bit stall_second = 0, stall_done = 0, abort_done = 0;
  bit rand_ctl = 0, hi_mode = 0, mig_stall = 0;
  logic [ADDR_W-1:0] hold_addr = '1;

  // Observation counters per session
  int sess_acc = 0, wr_cnt = 0, done_cnt = 0, hold_cnt = 0;
  logic [ADDR_W-1:0] acc_log[$];
  ret_t              ret_q[$];
  logic [DATA_W-1:0] exp_q[$];

  // Reference session model
  phase_t            m_phase = P_IDLE;
  logic [ADDR_W-1:0] m_base, m_addr;
  int                m_num, m_rem, m_inflight, m_prev_count;
  logic [15:0]       m_pass;
  bit                m_aborted, m_done, m_ovf, m_prev_valid, m_prev_calib;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
    return {8{3'b101, a}};
  endfunction

  // Per-cycle compare and reference update, mid-cycle.
  always @(negedge clk) begin : monitor
    bit acc, last, exp_en;
    int old_inf;
    if (!sys_rst) begin
      m_phase = P_IDLE; m_pass = '0; m_ovf = 0; m_done = 0; m_inflight = 0;
      m_prev_valid = 0; m_prev_calib = 0; m_prev_count = 0; m_rem = 0;
      exp_q.delete(); ret_q.delete();
    end else begin
      exp_en = (m_phase == P_ISSUE) && m_prev_calib && (m_prev_count + m_inflight < DEPTH);
      check("busy", busy, m_phase != P_IDLE);
      check("done", done, m_done);
      check("pass_cnt", pass_cnt, m_pass);
      check("overflow_err", overflow_err, m_ovf);
      check("app_en", app_en, exp_en);
      check("app_cmd", app_cmd, 3'b001);
      check("fifo_wr_en", fifo_wr_en, m_prev_valid);
      if (fifo_wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) check("fifo_wr_unexpected", 1'b1, 1'b0);
        else                   check("fifo_din", fifo_din, exp_q.pop_front());
      end
      if (done) done_cnt++;
      if (app_en && !app_rdy && app_addr == hold_addr) hold_cnt++;

      m_done  = 0;
      old_inf = m_inflight;
      acc     = app_en && app_rdy;
      last    = (m_rem == 1);
      if (acc) begin
        check("app_addr", app_addr, m_addr);
        ret_q.push_back('{addr: m_addr, due: cyc + lat});
        acc_log.push_back(app_addr);
        sess_acc++;
        m_inflight++;
        if (last) begin
          if (loop_en) begin m_addr = m_base; m_rem = m_num; m_pass++; end
        end else begin
          m_addr = m_addr + ADDR_W'(STEP);
          m_rem--;
        end
      end
      if (app_rd_data_valid) begin
        exp_q.push_back(app_rd_data);
        m_inflight--;
        if (fifo_wr_count >= DEPTH) m_ovf = 1;
      end
      case (m_phase)
        P_IDLE: if (start) begin
          if (num_words != 0) begin
            m_base = base_addr; m_addr = base_addr; m_num = int'(num_words);
            m_rem = m_num; m_aborted = 0; m_phase = P_WAIT;
          end else m_done = 1;
        end
        P_WAIT: if (abort) begin m_aborted = 1; m_phase = P_DRAIN; end
                else if (init_calib_complete) m_phase = P_ISSUE;
        P_ISSUE: if (abort) begin m_aborted = 1; m_phase = P_DRAIN; end
                 else if (acc && last && !loop_en) m_phase = P_DRAIN;
        P_DRAIN: if (old_inf == 0) begin
          m_done = 1;
          if (!m_aborted) m_pass++;
          m_phase = P_IDLE;
        end
        default: m_phase = P_IDLE;
      endcase
      m_prev_valid = app_rd_data_valid;
      m_prev_calib = init_calib_complete;
      m_prev_count = int'(fifo_wr_count);
    end
  end

  task automatic tick();
    ret_t r;
    @(posedge clk); #1;
    cyc++;
    start = 0; abort = 0;
    if (force_low > 0) begin app_rdy = 0; force_low--; end
    else app_rdy = ($urandom_range(99) < rdy_prob);
    if (stall_second && !stall_done && sess_acc == 1) begin
      app_rdy = 0; force_low = 2; stall_done = 1;
    end
    if (abort_after != 0 && !abort_done && sess_acc == abort_after) begin
      abort = 1; app_rdy = 0; abort_done = 1;
    end
    if (rand_ctl) begin
      init_calib_complete = ($urandom_range(99) >= 5);
      fifo_wr_count = hi_mode ? CNT_W'($urandom_range(490, DEPTH - 1)) : CNT_W'($urandom_range(0, 200));
      if (m_phase != P_IDLE) begin
        if ($urandom_range(199) == 0) abort = 1;
        if ($urandom_range(49) == 0) begin
          start = 1;
          num_words = LEN_W'($urandom_range(0, 12));
          base_addr = ADDR_W'($urandom);
        end
      end
    end
    app_rd_data_valid = 0;
    app_rd_data = '0;
    if (sys_rst && !mig_stall && ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      r = ret_q.pop_front();
      app_rd_data_valid = 1;
      app_rd_data = data_of(r.addr);
    end
  endtask

  task automatic begin_session(input logic [ADDR_W-1:0] base, input int num, input bit lp);
    sess_acc = 0; wr_cnt = 0; done_cnt = 0; hold_cnt = 0;
    stall_done = 0; abort_done = 0;
    acc_log.delete();
    tick();
    base_addr = base; num_words = LEN_W'(num); loop_en = lp; start = 1;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit ok = 0;
    tick();
    for (int i = 0; i < max_cycles; i++) begin
      if (m_phase == P_IDLE) begin ok = 1; break; end
      tick();
    end
    check("wait_idle_timeout", ok, 1'b1);
    repeat (3) tick();
  endtask

  task automatic wait_acc(input int n, input int max_cycles);
    for (int i = 0; i < max_cycles && sess_acc < n; i++) tick();
    check("wait_acc_timeout", sess_acc >= n, 1'b1);
  endtask

  initial begin
    logic [15:0] pass_before;
    sys_rst = 0; start = 0; abort = 0; loop_en = 0; base_addr = '0; num_words = '0;
    init_calib_complete = 1; app_rdy = 0; app_rd_data = '0; app_rd_data_valid = 0;
    fifo_wr_count = '0;
    repeat (3) @(posedge clk);
    #1 sys_rst = 1;
    repeat (4) tick();

    // Basic four-word pass, latency 10
    begin_session(29'h100, 4, 0);
    wait_idle(500);
    check("basic_addr0", acc_log[0], 29'h100);
    check("basic_addr1", acc_log[1], 29'h108);
    check("basic_addr2", acc_log[2], 29'h110);
    check("basic_addr3", acc_log[3], 29'h118);
    check("basic_writes", wr_cnt, 4);
    check("basic_done", done_cnt, 1);
    check("basic_pass", pass_cnt, 16'd1);
    check("basic_busy", busy, 1'b0);

    // app_rdy low for three cycles on the second command
    hold_addr = 29'h108; stall_second = 1;
    begin_session(29'h100, 4, 0);
    wait_idle(500);
    stall_second = 0; hold_addr = '1;
    check("stall_hold_cycles", hold_cnt, 3);
    check("stall_accepts", sess_acc, 4);
    check("stall_pass", pass_cnt, 16'd2);

    // Credit limit: FIFO two short of full, returns stalled
    fifo_wr_count = CNT_W'(DEPTH - 2); mig_stall = 1;
    begin_session(29'h1000, 10, 0);
    repeat (20) tick();
    check("credit_two_issued", sess_acc, 2);
    fifo_wr_count = '0;
    repeat (20) tick();
    check("credit_all_issued", sess_acc, 10);
    mig_stall = 0;
    wait_idle(500);
    check("credit_writes", wr_cnt, 10);
    check("credit_no_overflow", overflow_err, 1'b0);

    // Looping pass across the top of the address space
    lat = 4;
    pass_before = pass_cnt;
    begin_session(29'h1FFF_FFF8, 3, 1);
    wait_acc(9, 200);
    loop_en = 0;
    wait_idle(500);
    check("loop_addr0", acc_log[0], 29'h1FFF_FFF8);
    check("loop_addr1_wraps", acc_log[1], 29'h0);
    check("loop_addr2", acc_log[2], 29'h8);
    check("loop_addr3_reload", acc_log[3], 29'h1FFF_FFF8);
    check("loop_accepts", sess_acc, 12);
    check("loop_pass_delta", pass_cnt - pass_before, 16'd4);
    check("loop_done", done_cnt, 1);

    // Abort after two accepts
    lat = 10; abort_after = 2;
    pass_before = pass_cnt;
    begin_session(29'h2000, 8, 0);
    wait_idle(500);
    abort_after = 0;
    check("abort_accepts", sess_acc, 2);
    check("abort_writes", wr_cnt, 2);
    check("abort_done", done_cnt, 1);
    check("abort_pass_same", pass_cnt, pass_before);

    // Zero-length start
    begin_session(29'h40, 0, 0);
    wait_idle(50);
    check("zero_done", done_cnt, 1);
    check("zero_accepts", sess_acc, 0);
    check("zero_pass_same", pass_cnt, pass_before);

    // Asynchronous reset mid-issue, then a normal run
    begin_session(29'h4000, 20, 0);
    wait_acc(3, 200);
    tick();
    sys_rst = 0;
    #1;
    check("rst_app_en", app_en, 1'b0);
    check("rst_app_addr", app_addr, 29'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_en", fifo_wr_en, 1'b0);
    check("rst_fifo_din", fifo_din, '0);
    check("rst_pass", pass_cnt, 16'd0);
    check("rst_done", done, 1'b0);
    ret_q.delete();
    tick(); tick();
    sys_rst = 1;
    repeat (4) tick();
    begin_session(29'h200, 5, 0);
    wait_idle(500);
    check("post_rst_accepts", sess_acc, 5);
    check("post_rst_addr4", acc_log[4], 29'h220);
    check("post_rst_writes", wr_cnt, 5);
    check("post_rst_pass", pass_cnt, 16'd1);

    // Randomized sessions against the reference model
    rand_ctl = 1;
    for (int s = 0; s < 40; s++) begin
      rdy_prob = $urandom_range(40, 100);
      lat = $urandom_range(1, 20);
      hi_mode = ($urandom_range(3) == 0);
      begin_session(ADDR_W'($urandom), $urandom_range(0, 12), $urandom_range(3) == 0);
      repeat ($urandom_range(5, 60)) tick();
      loop_en = 0;
      wait_idle(3000);
    end
    rand_ctl = 0; rdy_prob = 100; lat = 10;
    init_calib_complete = 1; fifo_wr_count = '0;
    repeat (4) tick();

    // Data arriving with the FIFO reported full
    begin_session(29'h300, 2, 0);
    wait_acc(2, 100);
    fifo_wr_count = CNT_W'(DEPTH);
    wait_idle(500);
    check("ovf_set", overflow_err, 1'b1);
    check("ovf_still_written", wr_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
